fetch_seq: RTL and testbench

//   Fetch sequencer: owns the PC register and sequences it around control-flow instructions.
//   - Holds fetch while a branch or jump resolves.
//   - Redirects to the resolved target.
//   - Honours load-use and instruction-memory stalls.

---
 rtl/fetch_seq.sv | 110 +++++++++++
 tb/tb_fetch_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC and holds/redirects fetch around control flow.
// Optional stall perf counter enabled by defining FETCH_PERF_EN.
module fetch_seq #(
   parameter logic [31:0] RESET_PC       = 32'h0,
   parameter int unsigned RESOLVE_CYCLES = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [6:0]  opcode,
   input  logic        b_taken,
   input  logic [31:0] jump_target,
   input  logic        hazard_stall,
   input  logic        imem_ready,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_en,
   output logic        bubble,
   output logic        flush,
   output logic [1:0]  state,
   output logic [31:0] stall_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      RESOLVE  = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [1:0] CNT_INIT  = 2'(RESOLVE_CYCLES - 1);

   state_t      st;
   logic [1:0]  cnt;
   logic        is_jump;
   logic        is_jmp_op;
   logic        is_ctrl;
   logic [31:0] tgt;

   assign is_jmp_op = (opcode == OP_JAL) || (opcode == OP_JALR);
   assign is_ctrl   = is_jmp_op || (opcode == OP_BRANCH);
   assign tgt       = {jump_target[31:2], 2'b00};
   assign pc_plus4  = pc + 32'd4;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         pc      <= RESET_PC;
         st      <= RUN;
         cnt     <= 2'd0;
         is_jump <= 1'b0;
      end else begin
         case (st)
            RESOLVE: begin
               if (cnt != 2'd0) begin
                  cnt <= cnt - 2'd1;
               end else if (is_jump || b_taken) begin
                  pc <= tgt;
                  st <= REDIRECT;
               end else begin
                  pc <= pc_plus4;
                  st <= RUN;
               end
            end
            REDIRECT: begin
               if (imem_ready)
                  pc <= pc_plus4;
               st <= RUN;
            end
            // Encoding 3 is unreachable but behaves as RUN.
            default: begin
               if (hazard_stall) begin
                  st <= RUN;
               end else if (is_ctrl) begin
                  st      <= RESOLVE;
                  is_jump <= is_jmp_op;
                  cnt     <= CNT_INIT;
               end else if (imem_ready) begin
                  pc <= pc_plus4;
               end
            end
         endcase
      end
   end

   assign state    = st;
   assign bubble   = (st == RESOLVE);
   assign flush    = (st == REDIRECT);
   assign fetch_en = !RESET && (st != RESOLVE);

`ifdef FETCH_PERF_EN
   logic [31:0] perf_q;
   logic        perf_hit;

   assign perf_hit = (st == RESOLVE) ||
                     ((st != REDIRECT) && hazard_stall);

   always_ff @(posedge CLK) begin
      if (RESET)
         perf_q <= 32'd0;
      else if (perf_hit && (perf_q != 32'hFFFF_FFFF))
         perf_q <= perf_q + 32'd1;
   end

   assign stall_cnt = perf_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: RESOLVE_CYCLES=1 main instance,
// plus a RESOLVE_CYCLES=3 instance for the multi-cycle hold.
module tb_fetch_seq;

   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

`ifdef FETCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RESET;
   logic [6:0]  opcode;
   logic        b_taken;
   logic [31:0] jump_target;
   logic        hazard_stall;
   logic        imem_ready;

   logic [31:0] pc, pc_plus4, stall_cnt;
   logic        fetch_en, bubble, flush;
   logic [1:0]  state;

   logic [31:0] u2_pc, u2_pc_plus4, u2_stall_cnt;
   logic        u2_fetch_en, u2_bubble, u2_flush;
   logic [1:0]  u2_state;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   fetch_seq #(.RESET_PC(32'h100), .RESOLVE_CYCLES(1)) u_dut (
      .CLK(CLK), .RESET(RESET), .opcode(opcode), .b_taken(b_taken),
      .jump_target(jump_target), .hazard_stall(hazard_stall),
      .imem_ready(imem_ready), .pc(pc), .pc_plus4(pc_plus4),
      .fetch_en(fetch_en), .bubble(bubble), .flush(flush),
      .state(state), .stall_cnt(stall_cnt)
   );

   fetch_seq #(.RESET_PC(32'h100), .RESOLVE_CYCLES(3)) u_dut3 (
      .CLK(CLK), .RESET(RESET), .opcode(opcode), .b_taken(b_taken),
      .jump_target(jump_target), .hazard_stall(hazard_stall),
      .imem_ready(imem_ready), .pc(u2_pc), .pc_plus4(u2_pc_plus4),
      .fetch_en(u2_fetch_en), .bubble(u2_bubble), .flush(u2_flush),
      .state(u2_state), .stall_cnt(u2_stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic cyc(input string tag, input logic [31:0] e_pc,
                      input logic [1:0] e_st, input logic e_bub,
                      input logic e_fl, input logic e_fe);
      chk({tag, ".pc"}, pc, e_pc);
      chk({tag, ".state"}, 32'(state), 32'(e_st));
      chk({tag, ".bubble"}, 32'(bubble), 32'(e_bub));
      chk({tag, ".flush"}, 32'(flush), 32'(e_fl));
      chk({tag, ".fetch_en"}, 32'(fetch_en), 32'(e_fe));
   endtask

   initial begin
      RESET        = 1'b1;
      opcode       = OP_ALU;
      b_taken      = 1'b0;
      jump_target  = 32'h0;
      hazard_stall = 1'b0;
      imem_ready   = 1'b1;

      // reset
      step();
      step();
      cyc("rst", 32'h100, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("rst.stall_cnt", stall_cnt, 32'h0);
      RESET = 1'b0;
      #1;
      chk("rst.fetch_en_rel", 32'(fetch_en), 32'd1);

      // sequential
      step(); cyc("seq1", 32'h104, 2'd0, 1'b0, 1'b0, 1'b1);
      step(); cyc("seq2", 32'h108, 2'd0, 1'b0, 1'b0, 1'b1);
      step(); cyc("seq3", 32'h10C, 2'd0, 1'b0, 1'b0, 1'b1);
      chk("seq.pc_plus4", pc_plus4, 32'h110);
      imem_ready = 1'b0;
      step(); cyc("imem_hold", 32'h10C, 2'd0, 1'b0, 1'b0, 1'b1);
      imem_ready = 1'b1;

      // JAL to 0x200, REDIRECT with imem not ready holds pc
      opcode = OP_JAL; jump_target = 32'h200;
      step(); cyc("jal.res", 32'h10C, 2'd1, 1'b1, 1'b0, 1'b0);
      opcode = OP_ALU;
      step(); cyc("jal.redir", 32'h200, 2'd2, 1'b0, 1'b1, 1'b1);
      imem_ready = 1'b0;
      step(); cyc("jal.hold", 32'h200, 2'd0, 1'b0, 1'b0, 1'b1);
      imem_ready = 1'b1;

      // taken branch
      opcode = OP_BRANCH; b_taken = 1'b1; jump_target = 32'h240;
      step(); cyc("tk.c1", 32'h200, 2'd1, 1'b1, 1'b0, 1'b0);
      opcode = OP_ALU;
      step(); cyc("tk.c2", 32'h240, 2'd2, 1'b0, 1'b1, 1'b1);
      b_taken = 1'b0;
      step(); cyc("tk.c3", 32'h244, 2'd0, 1'b0, 1'b0, 1'b1);
      chk("tk.stall_cnt", stall_cnt, PERF ? 32'd2 : 32'd0);

      // not-taken branch
      opcode = OP_BRANCH; b_taken = 1'b0; jump_target = 32'h240;
      step(); cyc("nt.c1", 32'h244, 2'd1, 1'b1, 1'b0, 1'b0);
      opcode = OP_ALU;
      step(); cyc("nt.c2", 32'h248, 2'd0, 1'b0, 1'b0, 1'b1);

      // JALR to misaligned target
      opcode = OP_JALR; jump_target = 32'h303;
      step(); cyc("jalr.c1", 32'h248, 2'd1, 1'b1, 1'b0, 1'b0);
      opcode = OP_ALU;
      step(); cyc("jalr.c2", 32'h300, 2'd2, 1'b0, 1'b1, 1'b1);
      step(); cyc("jalr.c3", 32'h304, 2'd0, 1'b0, 1'b0, 1'b1);
      chk("jalr.stall_cnt", stall_cnt, PERF ? 32'd4 : 32'd0);

      // load-use stall over a branch
      hazard_stall = 1'b1; opcode = OP_BRANCH; jump_target = 32'h500;
      step(); cyc("hz.c1", 32'h304, 2'd0, 1'b0, 1'b0, 1'b1);
      step(); cyc("hz.c2", 32'h304, 2'd0, 1'b0, 1'b0, 1'b1);
      chk("hz.stall_cnt", stall_cnt, PERF ? 32'd6 : 32'd0);
      hazard_stall = 1'b0;
      step(); cyc("hz.res", 32'h304, 2'd1, 1'b1, 1'b0, 1'b0);
      opcode = OP_ALU;
      step(); cyc("hz.run", 32'h308, 2'd0, 1'b0, 1'b0, 1'b1);
      chk("hz.stall_cnt2", stall_cnt, PERF ? 32'd7 : 32'd0);

      // wrap-around at top of address space
      opcode = OP_JAL; jump_target = 32'hFFFF_FFFC;
      step();
      opcode = OP_ALU;
      step(); cyc("wrap.top", 32'hFFFF_FFFC, 2'd2, 1'b0, 1'b1, 1'b1);
      chk("wrap.pc_plus4", pc_plus4, 32'h0);
      step(); cyc("wrap.zero", 32'h0, 2'd0, 1'b0, 1'b0, 1'b1);

      // reset mid-RESOLVE
      opcode = OP_BRANCH;
      step(); chk("midrst.pre", 32'(state), 32'd1);
      RESET = 1'b1; opcode = OP_ALU;
      step(); cyc("midrst", 32'h100, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("midrst.stall_cnt", stall_cnt, 32'h0);

      // three-cycle resolve on the second instance
      chk("rc3.rst_pc", u2_pc, 32'h100);
      RESET = 1'b0;
      opcode = OP_BRANCH; b_taken = 1'b1; jump_target = 32'h1F0;
      step(); chk("rc3.c1", 32'(u2_state), 32'd1);
      opcode = OP_ALU;
      step(); chk("rc3.c2", 32'(u2_state), 32'd1);
      step(); chk("rc3.c3", 32'(u2_state), 32'd1);
      chk("rc3.c3_pc", u2_pc, 32'h100);
      step(); chk("rc3.redir", 32'(u2_state), 32'd2);
      chk("rc3.redir_pc", u2_pc, 32'h1F0);
      chk("rc3.flush", 32'(u2_flush), 32'd1);
      b_taken = 1'b0;
      step(); chk("rc3.run_pc", u2_pc, 32'h1F4);
      chk("rc3.stall_cnt", u2_stall_cnt, PERF ? 32'd3 : 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
